// File: rtl/life_controller.sv
// life_controller: LOAD/STEP/RUN/STOP command sequencer driving the 4x4 life array.
// Define LIFE_CTRL_HALT_DETECT_EN to end RUNs early on extinct or still-life generations.
module life_controller #(
    parameter int GEN_W = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [15:0]      cmd_data,
    input  logic [DIV_W-1:0] period,
    input  logic [GEN_W-1:0] gen_limit,
    output logic [15:0]      arr_val,
    output logic             arr_write_enb,
    output logic             arr_step,
    input  logic [15:0]      arr_alive,
    input  logic [15:0]      arr_alive_prev,
    output logic             busy,
    output logic             done,
    output logic [1:0]       halt_reason,
    output logic [GEN_W-1:0] gen_count,
    output logic             cmd_err
);

`ifdef LIFE_CTRL_HALT_DETECT_EN
    localparam bit HALT_DETECT = 1'b1;
`else
    localparam bit HALT_DETECT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_CHECK,
        S_WAIT
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam logic [1:0] HR_STOP    = 2'b00;
    localparam logic [1:0] HR_LIMIT   = 2'b01;
    localparam logic [1:0] HR_STILL   = 2'b10;
    localparam logic [1:0] HR_EXTINCT = 2'b11;

    state_t           state_q;
    logic             run_mode_q;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] cnt_q;
    logic [GEN_W-1:0] limit_q;
    logic [GEN_W-1:0] gen_count_q;
    logic [15:0]      arr_val_q;
    logic             write_enb_q;
    logic             step_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       reason_q;

    logic             accept;
    logic [DIV_W-1:0] period_d;
    logic [GEN_W-1:0] gen_count_d;
    logic             halt_d;
    logic [1:0]       halt_reason_d;

    // Ready is forced low while reset is asserted, independent of the state register.
    assign cmd_ready   = reset & ((state_q == S_IDLE) | (state_q == S_WAIT));
    assign accept      = cmd_valid & cmd_ready;
    assign period_d    = (period == '0) ? DIV_W'(1) : period;
    assign gen_count_d = gen_count_q + GEN_W'(1);

    // CHECK sees the freshly stepped generation on arr_alive.
    always_comb begin
        halt_d        = 1'b1;
        halt_reason_d = HR_STOP;
        if (!run_mode_q) begin
            halt_reason_d = HR_STOP;
        end else if (HALT_DETECT && (arr_alive == 16'h0000)) begin
            halt_reason_d = HR_EXTINCT;
        end else if (HALT_DETECT && (arr_alive == arr_alive_prev)) begin
            halt_reason_d = HR_STILL;
        end else if ((limit_q != '0) && (gen_count_q == limit_q)) begin
            halt_reason_d = HR_LIMIT;
        end else begin
            halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            run_mode_q  <= 1'b0;
            period_q    <= '0;
            cnt_q       <= '0;
            limit_q     <= '0;
            gen_count_q <= '0;
            arr_val_q   <= '0;
            write_enb_q <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            reason_q    <= HR_STOP;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        reason_q <= HR_STOP;
                        case (cmd_op)
                            OP_LOAD: begin
                                arr_val_q   <= cmd_data;
                                write_enb_q <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= S_LOAD;
                            end
                            OP_STEP: begin
                                run_mode_q <= 1'b0;
                                step_q     <= 1'b1;
                                busy_q     <= 1'b1;
                                state_q    <= S_STEP;
                            end
                            OP_RUN: begin
                                run_mode_q <= 1'b1;
                                period_q   <= period_d;
                                cnt_q      <= period_d;
                                limit_q    <= gen_limit;
                                busy_q     <= 1'b1;
                                state_q    <= S_WAIT;
                            end
                            default: begin
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    write_enb_q <= 1'b0;
                    gen_count_q <= '0;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                S_STEP: begin
                    step_q      <= 1'b0;
                    gen_count_q <= gen_count_d;
                    state_q     <= S_CHECK;
                end
                S_CHECK: begin
                    if (halt_d) begin
                        reason_q <= halt_reason_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q   <= period_q;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // STOP wins over a step falling due on the same edge.
                    if (accept && (cmd_op == OP_STOP)) begin
                        reason_q <= HR_STOP;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        if (accept) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_q == DIV_W'(1)) begin
                            step_q  <= 1'b1;
                            state_q <= S_STEP;
                        end else begin
                            cnt_q <= cnt_q - DIV_W'(1);
                        end
                    end
                end
                default: begin
                    write_enb_q <= 1'b0;
                    step_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign arr_val       = arr_val_q;
    assign arr_write_enb = write_enb_q;
    assign arr_step      = step_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign halt_reason   = reason_q;
    assign gen_count     = gen_count_q;
    assign cmd_err       = err_q;

endmodule

// File: tb/tb_life_controller.sv
// tb_life_controller: scoreboard bench for life_controller with a behavioural 4x4 life array.
`timescale 1ns/1ps
module tb_life_controller;
    localparam int GEN_W = 16;
    localparam int DIV_W = 24;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [15:0]      cmd_data = 16'h0000;
    logic [DIV_W-1:0] period = '0;
    logic [GEN_W-1:0] gen_limit = '0;
    logic [15:0]      arr_val;
    logic             arr_write_enb;
    logic             arr_step;
    logic [15:0]      arr_alive;
    logic [15:0]      arr_alive_prev;
    logic             busy;
    logic             done;
    logic [1:0]       halt_reason;
    logic [GEN_W-1:0] gen_count;
    logic             cmd_err;

    life_controller #(.GEN_W(GEN_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .period(period), .gen_limit(gen_limit),
        .arr_val(arr_val), .arr_write_enb(arr_write_enb), .arr_step(arr_step),
        .arr_alive(arr_alive), .arr_alive_prev(arr_alive_prev), .busy(busy),
        .done(done), .halt_reason(halt_reason), .gen_count(gen_count), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Stand-in for life_array_4x4 with all edge inputs tied dead.
    logic [15:0] alive_m = 16'h0000;
    logic [15:0] prev_m  = 16'h0000;

    function automatic logic [15:0] life_next(input logic [15:0] c);
        logic [15:0] n;
        int cnt;
        n = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                cnt = 0;
                for (int di = -1; di <= 1; di++) begin
                    for (int dj = -1; dj <= 1; dj++) begin
                        if (!(di == 0 && dj == 0) && (i + di) >= 0 && (i + di) < 4 &&
                            (j + dj) >= 0 && (j + dj) < 4)
                            cnt += int'(c[4 * (i + di) + (j + dj)]);
                    end
                end
                n[4 * i + j] = (cnt == 3) || (cnt == 2 && c[4 * i + j]);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (arr_write_enb) begin
            alive_m <= arr_val;
        end else if (arr_step) begin
            prev_m  <= alive_m;
            alive_m <= life_next(alive_m);
        end
    end
    assign arr_alive      = alive_m;
    assign arr_alive_prev = prev_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  reason;
        logic [15:0] gen;
        logic [15:0] alive;
        time         t_acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string n, input logic [1:0] r, input logic [15:0] g,
                        input logic [15:0] a, input time t, input int lat);
        exp_t e2;
        e2.name = n; e2.reason = r; e2.gen = g; e2.alive = a; e2.t_acc = t; e2.lat = lat;
        sb.push_back(e2);
    endtask

    int  step_cnt = 0;
    int  err_cnt = 0;
    int  excl_viol = 0;
    int  gap_min = 0;
    int  gap_max = 0;
    int  gap = 0;
    time last_step_t = 0;
    time first_step_t = 0;
    exp_t e;

    // Monitor: pops one expectation per done pulse and tracks step/err activity.
    always @(negedge clk) begin
        if (reset) begin
            if (arr_step && arr_write_enb) excl_viol++;
            if (cmd_err) err_cnt++;
            if (arr_step) begin
                if (step_cnt == 0) begin
                    first_step_t = $time;
                end else begin
                    gap = int'($time - last_step_t);
                    if (gap < gap_min) gap_min = gap;
                    if (gap > gap_max) gap_max = gap;
                end
                last_step_t = $time;
                step_cnt++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_reason"}, 32'(halt_reason), 32'(e.reason));
                    check({e.name, "_gen"}, 32'(gen_count), 32'(e.gen));
                    check({e.name, "_alive"}, 32'(arr_alive), 32'(e.alive));
                    check({e.name, "_busy"}, 32'(busy), 0);
                    if (e.lat >= 0) check({e.name, "_lat"}, 32'($time - e.t_acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic clear_stats();
        step_cnt = 0; err_cnt = 0; gap_min = 1000000; gap_max = 0;
        first_step_t = 0; last_step_t = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] data, output time t);
        int g;
        g = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            t = $time;
        end else begin
            @(posedge clk);
            t = $time;
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        int g;
        g = 0;
        while (sb.size() != 0 && g < max_cyc) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            check({nm, "_timeout"}, 32'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t;
        int  g;

        // Reset values
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_outs", 32'({arr_val, arr_write_enb, arr_step, busy, done, cmd_err, halt_reason}), 0);
        check("rst_gen_count", 32'(gen_count), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);

        // LOAD blinker then single STEP
        send(OP_LOAD, 16'h0070, t);
        push("load_blinker", 2'b00, 16'd0, 16'h0070, t, 15);
        wait_idle("load_blinker", 20);
        send(OP_STEP, 16'h0000, t);
        push("step_blinker", 2'b00, 16'd1, 16'h0222, t, 25);
        wait_idle("step_blinker", 20);

        // STOP while idle
        send(OP_STOP, 16'h0000, t);
        push("stop_idle", 2'b00, 16'd1, 16'h0222, t, 5);
        wait_idle("stop_idle", 20);

        // Block still life
        send(OP_LOAD, 16'h0660, t);
        push("load_block", 2'b00, 16'd0, 16'h0660, t, 15);
        wait_idle("load_block", 20);
        period = 24'd2; gen_limit = 16'd0;
        send(OP_RUN, 16'h0000, t);
`ifdef LIFE_CTRL_HALT_DETECT_EN
        push("run_still", 2'b10, 16'd1, 16'h0660, t, -1);
        wait_idle("run_still", 200);
`else
        g = 0;
        while (gen_count != 16'd10 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("block_gen10", 32'(gen_count), 10);
        check("block_gen10_busy", 32'(busy), 1);
        send(OP_STOP, 16'h0000, t);
        push("block_stop", 2'b00, 16'd10, 16'h0660, t, 5);
        wait_idle("block_stop", 20);
`endif

        // Single cell dies; period 0 behaves as 1
        send(OP_LOAD, 16'h0001, t);
        push("load_single", 2'b00, 16'd0, 16'h0001, t, 15);
        wait_idle("load_single", 20);
        period = 24'd0; gen_limit = 16'd3;
        clear_stats();
        send(OP_RUN, 16'h0000, t);
`ifdef LIFE_CTRL_HALT_DETECT_EN
        push("run_extinct", 2'b11, 16'd1, 16'h0000, t, -1);
`else
        push("run_extinct", 2'b01, 16'd3, 16'h0000, t, -1);
`endif
        wait_idle("run_extinct", 200);
        check("period0_first_step", 32'(first_step_t - t), 15);

        // Generation limit with period 3
        send(OP_LOAD, 16'h0070, t);
        push("load_limit", 2'b00, 16'd0, 16'h0070, t, 15);
        wait_idle("load_limit", 20);
        period = 24'd3; gen_limit = 16'd4;
        clear_stats();
        send(OP_RUN, 16'h0000, t);
        push("run_limit", 2'b01, 16'd4, 16'h0070, t, -1);
        wait_idle("run_limit", 200);
        check("limit_steps", 32'(step_cnt), 4);
        check("limit_gap_min", 32'(gap_min), 50);
        check("limit_gap_max", 32'(gap_max), 50);
        check("limit_first_step", 32'(first_step_t - t), 35);

        // Dropped STEP during WAIT, then STOP during the second WAIT
        send(OP_LOAD, 16'h6186, t);
        push("load_stop", 2'b00, 16'd0, 16'h6186, t, 15);
        wait_idle("load_stop", 20);
        period = 24'd10; gen_limit = 16'd0;
        clear_stats();
        send(OP_RUN, 16'h0000, t);
        repeat (2) @(negedge clk);
        send(OP_STEP, 16'h0000, t);
        repeat (3) @(negedge clk);
        check("drop_err_pulse", 32'(err_cnt), 1);
        check("drop_no_step", 32'(step_cnt), 0);
        check("drop_busy", 32'(busy), 1);
        g = 0;
        while (step_cnt < 1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        send(OP_STOP, 16'h0000, t);
        push("run_stop", 2'b00, 16'd1, 16'h2664, t, 5);
        wait_idle("run_stop", 20);
        repeat (30) @(negedge clk);
        check("stop_no_more_steps", 32'(step_cnt), 1);
        check("stop_err_total", 32'(err_cnt), 1);

        // Asynchronous reset during a RUN step cycle
        send(OP_LOAD, 16'h0070, t);
        push("load_rst", 2'b00, 16'd0, 16'h0070, t, 15);
        wait_idle("load_rst", 20);
        period = 24'd2; gen_limit = 16'd0;
        send(OP_RUN, 16'h0000, t);
        g = 0;
        while (!(arr_step && gen_count == 16'd1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_step_seen", 32'(arr_step), 1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_step", 32'(arr_step), 0);
        check("rst_async_ready", 32'(cmd_ready), 0);
        check("rst_async_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(cmd_ready), 1);
        check("rel_busy", 32'(busy), 0);
        check("rel_gen_count", 32'(gen_count), 0);
        check("rel_reason", 32'(halt_reason), 0);
        repeat (10) @(negedge clk);
        check("rel_idle_no_step", 32'(arr_step), 0);

        check("step_we_exclusive", 32'(excl_viol), 0);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
